// File: rtl/mac_config_ctrl.sv
// Shadow/active config controller for the MAC parser: ACL regs + dest CAM.
// Optional readback port enabled by MAC_CFG_READBACK_EN.
module mac_config_ctrl #(
  parameter int NUM_CAM_ENTRIES = 16,
  parameter int ADDR_W          = 6
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          cfg_wr_en,
  input  logic [ADDR_W-1:0]             cfg_wr_addr,
  input  logic [31:0]                   cfg_wr_data,
  input  logic                          cfg_commit,
  output logic                          cfg_busy,
  output logic                          cfg_wr_err,
  input  logic                          mon_tvalid,
  input  logic                          mon_tready,
  input  logic                          mon_tlast,
  output logic                          cfg_hold,
`ifdef MAC_CFG_READBACK_EN
  input  logic                          cfg_rd_en,
  input  logic [ADDR_W-1:0]             cfg_rd_addr,
  input  logic                          cfg_rd_sel,
  output logic [31:0]                   cfg_rd_data,
  output logic                          cfg_rd_valid,
`endif
  output logic [99:0]                   mac_config_regs,
  output logic [49*NUM_CAM_ENTRIES-1:0] mac_cam_values,
  output logic [7:0]                    cfg_generation
);

  localparam int REG_W   = 100;
  localparam int CAM_W   = 49 * NUM_CAM_ENTRIES;
  localparam int CAM_END = 8 + 2 * NUM_CAM_ENTRIES;

  typedef enum logic {
    IDLE,
    PENDING
  } state_t;

  state_t             state;
  logic               busy;
  logic               in_pkt;
  logic               beat;
  logic               boundary;
  logic               wr_err_q;
  logic [7:0]         gen;
  logic [REG_W-1:0]   sh_regs;
  logic [REG_W-1:0]   act_regs;
  logic [CAM_W-1:0]   sh_cam;
  logic [CAM_W-1:0]   act_cam;

  logic               wr_cam_hit;
  logic               wr_mapped;
  logic [ADDR_W-1:0]  wr_cam_off;
  logic [ADDR_W-2:0]  wr_cam_idx;

  function automatic logic cam_addr(input logic [ADDR_W-1:0] a);
    logic [ADDR_W:0] ax;
    ax = {1'b0, a};
    return (ax >= (ADDR_W+1)'(8)) && (ax < (ADDR_W+1)'(CAM_END));
  endfunction

  function automatic logic reg_addr(input logic [ADDR_W-1:0] a);
    logic [ADDR_W:0] ax;
    ax = {1'b0, a};
    return ax < (ADDR_W+1)'(5);
  endfunction

  assign beat       = mon_tvalid & mon_tready;
  assign boundary   = ~in_pkt & ~mon_tvalid;
  assign wr_cam_hit = cam_addr(cfg_wr_addr);
  assign wr_mapped  = wr_cam_hit | reg_addr(cfg_wr_addr);
  assign wr_cam_off = cfg_wr_addr - ADDR_W'(8);
  assign wr_cam_idx = wr_cam_off[ADDR_W-1:1];

  assign cfg_busy        = busy;
  assign cfg_hold        = busy & ~in_pkt;
  assign cfg_wr_err      = wr_err_q;
  assign cfg_generation  = gen;
  assign mac_config_regs = act_regs;
  assign mac_cam_values  = act_cam;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      in_pkt <= 1'b0;
    end else if (beat) begin
      in_pkt <= ~mon_tlast;
    end
  end

  // Shadow only accepts writes while no commit is outstanding.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      sh_regs  <= '0;
      sh_cam   <= '0;
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= cfg_wr_en & ((state == PENDING) | ~wr_mapped);
      if (cfg_wr_en && state == IDLE) begin
        case (cfg_wr_addr)
          ADDR_W'(0): sh_regs[1:0]   <= cfg_wr_data[1:0];
          ADDR_W'(1): sh_regs[33:2]  <= cfg_wr_data;
          ADDR_W'(2): sh_regs[50:34] <= cfg_wr_data[16:0];
          ADDR_W'(3): sh_regs[82:51] <= cfg_wr_data;
          ADDR_W'(4): sh_regs[99:83] <= cfg_wr_data[16:0];
          default: ;
        endcase
        for (int i = 0; i < NUM_CAM_ENTRIES; i++) begin
          if (wr_cam_hit && wr_cam_idx == (ADDR_W-1)'(i)) begin
            if (!wr_cam_off[0])
              sh_cam[49*i +: 32] <= cfg_wr_data;
            else
              sh_cam[49*i+32 +: 17] <= cfg_wr_data[16:0];
          end
        end
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      gen      <= 8'd0;
      act_regs <= '0;
      act_cam  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cfg_commit) begin
            state <= PENDING;
            busy  <= 1'b1;
          end
        end
        PENDING: begin
          if (boundary) begin
            state    <= IDLE;
            busy     <= 1'b0;
            act_regs <= sh_regs;
            act_cam  <= sh_cam;
            gen      <= gen + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef MAC_CFG_READBACK_EN
  function automatic logic [31:0] rd_word(
    input logic [REG_W-1:0]  regs,
    input logic [CAM_W-1:0]  cam,
    input logic [ADDR_W-1:0] a
  );
    logic [31:0]       w;
    logic [ADDR_W-1:0] off;
    w   = '0;
    off = a - ADDR_W'(8);
    case (a)
      ADDR_W'(0): w[1:0]  = regs[1:0];
      ADDR_W'(1): w       = regs[33:2];
      ADDR_W'(2): w[16:0] = regs[50:34];
      ADDR_W'(3): w       = regs[82:51];
      ADDR_W'(4): w[16:0] = regs[99:83];
      default: ;
    endcase
    for (int i = 0; i < NUM_CAM_ENTRIES; i++) begin
      if (cam_addr(a) && off[ADDR_W-1:1] == (ADDR_W-1)'(i)) begin
        if (!off[0])
          w = cam[49*i +: 32];
        else
          w[16:0] = cam[49*i+32 +: 17];
      end
    end
    return w;
  endfunction

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cfg_rd_data  <= 32'd0;
      cfg_rd_valid <= 1'b0;
    end else begin
      cfg_rd_valid <= cfg_rd_en;
      if (cfg_rd_en) begin
        if (cfg_rd_sel)
          cfg_rd_data <= rd_word(act_regs, act_cam, cfg_rd_addr);
        else
          cfg_rd_data <= rd_word(sh_regs, sh_cam, cfg_rd_addr);
      end
    end
  end
`endif

endmodule
